// File: rtl/dpram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dpram_arb_pkg
// Brief   : Shared types and constants for the DPRAM port arbiter.
// Revision: 1.0
// ============================================================================
package dpram_arb_pkg;

    localparam int NumReq       = 2;
    localparam int MaxDataWidth = 64;
    localparam int MaxBeWidth   = 8;
    localparam int MaxAddrWidth = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    // Sized for the widest supported configuration; narrower ports zero-extend.
    typedef struct packed {
        logic                    we;
        logic [MaxAddrWidth-1:0] addr;
        logic [MaxDataWidth-1:0] din;
        logic [MaxBeWidth-1:0]   be;
    } req_t;

endpackage
`default_nettype wire

// File: rtl/dpram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : dpram_port_arbiter_if
// Brief   : Requester handshakes and RAM port bundle of the DPRAM arbiter.
// Revision: 1.0
// ============================================================================
interface dpram_port_arbiter_if #(
    parameter int ByteLength = 8,
    parameter int DataWidth  = 32,
    parameter int BeWidth    = DataWidth / ByteLength,
    parameter int Depth      = 1280,
    parameter int AddrWidth  = $clog2(Depth)
);
    logic                 r0_req_i,    r1_req_i;
    logic                 r0_lock_i,   r1_lock_i;
    logic                 r0_we_i,     r1_we_i;
    logic [AddrWidth-1:0] r0_addr_i,   r1_addr_i;
    logic [DataWidth-1:0] r0_din_i,    r1_din_i;
    logic [BeWidth-1:0]   r0_be_i,     r1_be_i;
    logic                 r0_gnt_o,    r1_gnt_o;
    logic                 r0_rvalid_o, r1_rvalid_o;
    logic [DataWidth-1:0] r0_rdata_o,  r1_rdata_o;
    logic [AddrWidth-1:0] ram_addr_o;
    logic [DataWidth-1:0] ram_din_o;
    logic [BeWidth-1:0]   ram_be_o;
    logic                 ram_wren_o;
    logic                 ram_rden_o;
    logic [DataWidth-1:0] ram_dout_i;

    modport slave (
        input  r0_req_i, r0_lock_i, r0_we_i, r0_addr_i, r0_din_i, r0_be_i,
        input  r1_req_i, r1_lock_i, r1_we_i, r1_addr_i, r1_din_i, r1_be_i,
        input  ram_dout_i,
        output r0_gnt_o, r0_rvalid_o, r0_rdata_o,
        output r1_gnt_o, r1_rvalid_o, r1_rdata_o,
        output ram_addr_o, ram_din_o, ram_be_o, ram_wren_o, ram_rden_o
    );

    modport master (
        output r0_req_i, r0_lock_i, r0_we_i, r0_addr_i, r0_din_i, r0_be_i,
        output r1_req_i, r1_lock_i, r1_we_i, r1_addr_i, r1_din_i, r1_be_i,
        output ram_dout_i,
        input  r0_gnt_o, r0_rvalid_o, r0_rdata_o,
        input  r1_gnt_o, r1_rvalid_o, r1_rdata_o,
        input  ram_addr_o, ram_din_o, ram_be_o, ram_wren_o, ram_rden_o
    );
endinterface
`default_nettype wire

// File: rtl/dpram_arb_core.sv
`default_nettype none
// ============================================================================
// Module  : dpram_arb_core
// Brief   : Pure next-grant logic: state, pointer, req and lock to grant and
//           next state. DPRAM_ARB_RR_EN selects round-robin over fixed priority.
// Revision: 1.0
// ============================================================================
module dpram_arb_core
    import dpram_arb_pkg::*;
(
    input  state_t            state_i,
`ifdef DPRAM_ARB_RR_EN
    input  logic              ptr_i,
    output logic              ptr_d_o,
`endif
    input  logic [NumReq-1:0] req_i,
    input  logic [NumReq-1:0] lock_i,
    output logic [NumReq-1:0] gnt_o,
    output state_t            state_d_o
);

    always_comb begin
        gnt_o     = '0;
        state_d_o = state_i;
`ifdef DPRAM_ARB_RR_EN
        ptr_d_o   = ptr_i;
`endif
        case (state_i)
            IDLE: begin
                if (req_i[0] && req_i[1]) begin
`ifdef DPRAM_ARB_RR_EN
                    gnt_o = ptr_i ? 2'b10 : 2'b01;
`else
                    gnt_o = 2'b01;
`endif
                end else begin
                    gnt_o = req_i;
                end
                if (gnt_o[0] && lock_i[0]) begin
                    state_d_o = OWN0;
                end else if (gnt_o[1] && lock_i[1]) begin
                    state_d_o = OWN1;
                end
            end
            // While owning, a dropped lock ends ownership whether or not the
            // owner is granted this cycle.
            OWN0: begin
                gnt_o = {1'b0, req_i[0]};
                if (!lock_i[0]) begin
                    state_d_o = IDLE;
                end
            end
            OWN1: begin
                gnt_o = {req_i[1], 1'b0};
                if (!lock_i[1]) begin
                    state_d_o = IDLE;
                end
            end
            default: begin
                state_d_o = IDLE;
            end
        endcase
`ifdef DPRAM_ARB_RR_EN
        if (gnt_o[0]) begin
            ptr_d_o = 1'b1;
        end else if (gnt_o[1]) begin
            ptr_d_o = 1'b0;
        end
`endif
    end

endmodule
`default_nettype wire

// File: rtl/dpram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : dpram_port_arbiter
// Brief   : Shares one DPRAM port between two requesters with optional lock.
//           Define DPRAM_ARB_RR_EN for round-robin, otherwise r0 has priority.
// Revision: 1.0
// ============================================================================
module dpram_port_arbiter
    import dpram_arb_pkg::*;
#(
    parameter int ByteLength = 8,
    parameter int DataWidth  = 32,
    parameter int BeWidth    = DataWidth / ByteLength,
    parameter int Depth      = 1280,
    parameter int AddrWidth  = $clog2(Depth)
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    dpram_port_arbiter_if.slave  bus
);

    state_t            state_q, state_d;
    logic [NumReq-1:0] w_req, w_lock, w_gnt;
    req_t              w_rq [NumReq];
    req_t              w_sel;
    logic              pend_vld_q, pend_vld_d;
    logic              pend_id_q,  pend_id_d;
`ifdef DPRAM_ARB_RR_EN
    logic              ptr_q, ptr_d;
`endif

    assign w_req  = {bus.r1_req_i,  bus.r0_req_i};
    assign w_lock = {bus.r1_lock_i, bus.r0_lock_i};

    dpram_arb_core u_core (
        .state_i   (state_q),
`ifdef DPRAM_ARB_RR_EN
        .ptr_i     (ptr_q),
        .ptr_d_o   (ptr_d),
`endif
        .req_i     (w_req),
        .lock_i    (w_lock),
        .gnt_o     (w_gnt),
        .state_d_o (state_d)
    );

    always_comb begin
        w_rq[0].we   = bus.r0_we_i;
        w_rq[0].addr = MaxAddrWidth'(bus.r0_addr_i);
        w_rq[0].din  = MaxDataWidth'(bus.r0_din_i);
        w_rq[0].be   = MaxBeWidth'(bus.r0_be_i);
        w_rq[1].we   = bus.r1_we_i;
        w_rq[1].addr = MaxAddrWidth'(bus.r1_addr_i);
        w_rq[1].din  = MaxDataWidth'(bus.r1_din_i);
        w_rq[1].be   = MaxBeWidth'(bus.r1_be_i);
    end

    // Ungranted cycles present an all-zero request to the RAM port.
    always_comb begin
        w_sel = '0;
        if (w_gnt[0]) begin
            w_sel = w_rq[0];
        end else if (w_gnt[1]) begin
            w_sel = w_rq[1];
        end
    end

    assign bus.r0_gnt_o   = w_gnt[0];
    assign bus.r1_gnt_o   = w_gnt[1];
    assign bus.ram_addr_o = AddrWidth'(w_sel.addr);
    assign bus.ram_din_o  = DataWidth'(w_sel.din);
    assign bus.ram_be_o   = BeWidth'(w_sel.be);
    assign bus.ram_wren_o = w_sel.we;
    assign bus.ram_rden_o = (|w_gnt) & ~w_sel.we;

    assign pend_vld_d = bus.ram_rden_o;
    assign pend_id_d  = w_gnt[1];

    assign bus.r0_rvalid_o = pend_vld_q & ~pend_id_q;
    assign bus.r1_rvalid_o = pend_vld_q &  pend_id_q;
    assign bus.r0_rdata_o  = bus.r0_rvalid_o ? bus.ram_dout_i : '0;
    assign bus.r1_rdata_o  = bus.r1_rvalid_o ? bus.ram_dout_i : '0;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= IDLE;
            pend_vld_q <= 1'b0;
            pend_id_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_vld_q <= pend_vld_d;
            pend_id_q  <= pend_id_d;
        end
    end

`ifdef DPRAM_ARB_RR_EN
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dpram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_dpram_port_arbiter
// Brief   : Directed and random bench for dpram_port_arbiter with a RAM model.
// Revision: 1.0
// ============================================================================
module tb_dpram_port_arbiter;

    localparam int DW    = 32;
    localparam int BW    = 4;
    localparam int DEPTH = 1280;
    localparam int AW    = 11;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    dpram_port_arbiter_if #(.ByteLength(8), .DataWidth(DW), .Depth(DEPTH)) bus ();

    dpram_port_arbiter #(.ByteLength(8), .DataWidth(DW), .Depth(DEPTH)) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

    logic          rq [2];
    logic          lk [2];
    logic          we [2];
    logic [AW-1:0] ad [2];
    logic [DW-1:0] dn [2];
    logic [BW-1:0] be [2];

    assign bus.r0_req_i  = rq[0];  assign bus.r1_req_i  = rq[1];
    assign bus.r0_lock_i = lk[0];  assign bus.r1_lock_i = lk[1];
    assign bus.r0_we_i   = we[0];  assign bus.r1_we_i   = we[1];
    assign bus.r0_addr_i = ad[0];  assign bus.r1_addr_i = ad[1];
    assign bus.r0_din_i  = dn[0];  assign bus.r1_din_i  = dn[1];
    assign bus.r0_be_i   = be[0];  assign bus.r1_be_i   = be[1];

    // Environment RAM (driven by DUT port) and reference memory (driven by model)
    logic [DW-1:0] ram [DEPTH];
    logic [DW-1:0] mdl [DEPTH];

    int          compared   = 0;
    int          mismatched = 0;
    int          own;          // -1: nobody owns the port, else owner index
    int          rrn;          // requester that wins a tie next
    bit          pv;           // a read response is due this cycle
    int          pid;
    logic [31:0] pdat;
    logic [1:0]  last_g;
    logic [1:0]  prev_g;
    bit          act [2];

    function automatic logic [31:0] pre(input int i);
        if (i == 5) return 32'hDEADBEEF;
        if (i == 7) return 32'h0;
        return 32'hA500_0000 ^ (i * 32'h0001_0203);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input int n, input bit r, input bit l, input bit w,
                       input int a, input logic [31:0] d, input logic [3:0] b);
        rq[n] = r; lk[n] = l; we[n] = w; ad[n] = AW'(a); dn[n] = d; be[n] = b;
    endtask

    task automatic idle_all();
        drv(0, 0, 0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0, 0);
    endtask

    // One clock cycle: inputs are already stable; check at negedge, advance at posedge.
    task automatic step();
        logic [1:0]    g;
        int            k;
        int            w;
        logic          e_w, e_r;
        logic [AW-1:0] e_a;
        logic [DW-1:0] e_d;
        logic [BW-1:0] e_b;
        @(negedge clk);
        g = 2'b00;
        if (own == 0)      g[0] = rq[0];
        else if (own == 1) g[1] = rq[1];
        else if (rq[0] && rq[1]) begin
`ifdef DPRAM_ARB_RR_EN
            w = rrn;
`else
            w = 0;
`endif
            g[w] = 1'b1;
        end else g = {rq[1], rq[0]};
        k = g[1] ? 1 : (g[0] ? 0 : -1);
        chk("gnt0", bus.r0_gnt_o, g[0]);
        chk("gnt1", bus.r1_gnt_o, g[1]);
        chk("rvalid0", bus.r0_rvalid_o, pv && pid == 0);
        chk("rvalid1", bus.r1_rvalid_o, pv && pid == 1);
        chk("rdata0", bus.r0_rdata_o, (pv && pid == 0) ? pdat : 32'h0);
        chk("rdata1", bus.r1_rdata_o, (pv && pid == 1) ? pdat : 32'h0);
        if (k >= 0) begin
            chk("wren", bus.ram_wren_o, we[k]);
            chk("rden", bus.ram_rden_o, !we[k]);
            chk("addr", bus.ram_addr_o, ad[k]);
            chk("din",  bus.ram_din_o,  dn[k]);
            chk("be",   bus.ram_be_o,   be[k]);
        end else begin
            chk("wren_idle", bus.ram_wren_o, 0);
            chk("rden_idle", bus.ram_rden_o, 0);
            chk("addr_idle", bus.ram_addr_o, 0);
        end
        e_w = bus.ram_wren_o; e_r = bus.ram_rden_o; e_a = bus.ram_addr_o;
        e_d = bus.ram_din_o;  e_b = bus.ram_be_o;
        prev_g = last_g;
        last_g = g;
        @(posedge clk);
        if (e_r === 1'b1) bus.ram_dout_i = ram[e_a];
        if (e_w === 1'b1)
            for (int b = 0; b < BW; b++)
                if (e_b[b]) ram[e_a][8*b +: 8] = e_d[8*b +: 8];
        pv = 0;
        if (k >= 0) begin
            if (we[k]) begin
                for (int b = 0; b < BW; b++)
                    if (be[k][b]) mdl[ad[k]][8*b +: 8] = dn[k][8*b +: 8];
            end else begin
                pv = 1; pid = k; pdat = mdl[ad[k]];
            end
            own = lk[k] ? k : -1;
            rrn = 1 - k;
        end else if (own >= 0 && !rq[own] && !lk[own]) begin
            own = -1;
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ram[i] = pre(i);
            mdl[i] = pre(i);
        end
        bus.ram_dout_i = '0;
        idle_all();
        own = -1; rrn = 0; pv = 0; pid = 0; pdat = 0; last_g = 0; prev_g = 0;
        act[0] = 0; act[1] = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt0", bus.r0_gnt_o, 0);
        chk("rst_gnt1", bus.r1_gnt_o, 0);
        chk("rst_rvalid0", bus.r0_rvalid_o, 0);
        chk("rst_rvalid1", bus.r1_rvalid_o, 0);
        chk("rst_rdata0", bus.r0_rdata_o, 0);
        chk("rst_wren", bus.ram_wren_o, 0);
        chk("rst_rden", bus.ram_rden_o, 0);
        rstn = 1'b1;

        // Single read of the preloaded word
        drv(0, 1, 0, 0, 5, 0, 0);
        step();
        chk("sr_gnt", last_g, 2'b01);
        idle_all();
        chk("sr_rvalid", bus.r0_rvalid_o, 1);
        chk("sr_rdata", bus.r0_rdata_o, 32'hDEADBEEF);
        chk("sr_r1_rvalid", bus.r1_rvalid_o, 0);
        chk("sr_r1_rdata", bus.r1_rdata_o, 0);
        step();

        // Contention: both requesters read every cycle
        drv(0, 1, 0, 0, 1, 0, 0);
        drv(1, 1, 0, 0, 2, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step();
`ifdef DPRAM_ARB_RR_EN
            if (i > 0) chk("cont_alt", last_g, ~prev_g);
`else
            chk("cont_fixed", last_g, 2'b01);
`endif
        end
        idle_all();
        step();

        // Byte write then immediate read-back
        drv(1, 1, 0, 1, 7, 32'h11223344, 4'b0101);
        step();
        drv(1, 1, 0, 0, 7, 0, 0);
        step();
        idle_all();
        chk("bw_rdata", bus.r1_rdata_o, 32'h00220044);
        step();

        // Lock: r1 owns the port for three writes while r0 waits
        drv(1, 1, 1, 1, 8, 32'h0000_0008, 4'hF);
        step();
        chk("lk_a", last_g, 2'b10);
        drv(0, 1, 0, 0, 9, 0, 0);
        drv(1, 1, 1, 1, 9, 32'h0000_0009, 4'hF);
        step();
        chk("lk_b", last_g, 2'b10);
        drv(1, 1, 0, 1, 10, 32'h0000_000A, 4'hF);
        step();
        chk("lk_c", last_g, 2'b10);
        drv(1, 0, 0, 0, 0, 0, 0);
        step();
        chk("lk_d", last_g, 2'b01);
        idle_all();
        step();

        // Back-to-back alternating reads
        drv(0, 1, 0, 0, 1, 0, 0);
        step();
        idle_all();
        drv(1, 1, 0, 0, 2, 0, 0);
        chk("b2b_r0", bus.r0_rdata_o, pre(1));
        step();
        idle_all();
        drv(0, 1, 0, 0, 3, 0, 0);
        chk("b2b_r1", bus.r1_rdata_o, pre(2));
        step();
        idle_all();
        chk("b2b_r0b", bus.r0_rdata_o, pre(3));
        step();

        // Reset while a locked read's response is outstanding
        drv(0, 1, 1, 0, 5, 0, 0);
        step();
        chk("rr_pre_rvalid", bus.r0_rvalid_o, 1);
        idle_all();
        rstn = 1'b0;
        #1;
        chk("rr_rvalid", bus.r0_rvalid_o, 0);
        chk("rr_rdata", bus.r0_rdata_o, 0);
        own = -1; pv = 0; rrn = 0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        drv(1, 1, 0, 0, 2, 0, 0);
        step();
        chk("rr_idle", last_g, 2'b10);
        idle_all();
        step();

        // Random traffic obeying the hold-until-grant handshake
        for (int c = 0; c < 400; c++) begin
            for (int n = 0; n < 2; n++) begin
                if (!act[n] && $urandom_range(0, 2) == 0) begin
                    act[n] = 1;
                    drv(n, 1, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                        $urandom_range(0, 15), $urandom, 4'($urandom_range(0, 15)));
                end else if (!act[n]) begin
                    drv(n, 0, 0, 0, 0, 0, 0);
                end
            end
            step();
            for (int n = 0; n < 2; n++)
                if (last_g[n]) act[n] = 0;
        end
        idle_all();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
